// File: rtl/operand_bypass_stage_pkg.sv
// Shared types and defaults for the operand bypass stage.
// The perf counters are present only when OPERAND_BYPASS_PERF_EN is defined.
package operand_bypass_stage_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_NUM_OPS = 3;
  localparam int DEF_ADDR_W  = 5;
  localparam int CNT_W       = 32;

  // History entry at the default datapath sizes.
  typedef struct packed {
    logic                  valid;
    logic                  pend;
    logic [DEF_ADDR_W-1:0] dest;
    logic [DEF_WIDTH-1:0]  data;
  } bypass_entry_t;

  // Where a resolved operand came from; SRC_WAIT blocks issue.
  typedef enum logic [1:0] {
    SRC_RF   = 2'd0,
    SRC_HIST = 2'd1,
    SRC_CPL  = 2'd2,
    SRC_WAIT = 2'd3
  } op_src_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/operand_bypass_stage_if.sv
// Bus bundle for the operand bypass stage: writeback, completion, fetch and execute sides.
// Optional perf counters (OPERAND_BYPASS_PERF_EN) always exist here; they read 0 when disabled.
interface operand_bypass_stage_if
  import operand_bypass_stage_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int ADDR_W  = DEF_ADDR_W
);
  logic                             hist_adv;
  logic                             wb_valid;
  logic [ADDR_W-1:0]                wb_dest;
  logic [WIDTH-1:0]                 wb_data;
  logic                             wb_pend;
  logic                             cpl_valid;
  logic [ADDR_W-1:0]                cpl_dest;
  logic [WIDTH-1:0]                 cpl_data;

  // valid/ready: a beat moves on a clock edge where valid && ready are both high;
  // the sender holds its payload stable while valid && !ready, and ready may
  // depend combinationally on valid.
  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_OPS-1:0][ADDR_W-1:0]   in_src;
  logic [NUM_OPS-1:0][WIDTH-1:0]    in_rf;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_OPS-1:0][WIDTH-1:0]    out_op;

  logic                             hazard;
  logic                             overflow_err;
  logic [CNT_W-1:0]                 perf_fwd_cnt;
  logic [CNT_W-1:0]                 perf_stall_cnt;

  modport master (
    output hist_adv, wb_valid, wb_dest, wb_data, wb_pend,
    output cpl_valid, cpl_dest, cpl_data,
    output in_valid, in_src, in_rf, out_ready,
    input  in_ready, out_valid, out_op, hazard, overflow_err,
    input  perf_fwd_cnt, perf_stall_cnt
  );

  modport slave (
    input  hist_adv, wb_valid, wb_dest, wb_data, wb_pend,
    input  cpl_valid, cpl_dest, cpl_data,
    input  in_valid, in_src, in_rf, out_ready,
    output in_ready, out_valid, out_op, hazard, overflow_err,
    output perf_fwd_cnt, perf_stall_cnt
  );

endinterface

// File: rtl/operand_bypass_stage_history.sv
// Result history shift buffer: writeback insert, completion fill of pending
// placeholders, age-out overflow detect and per-operand youngest-match lookup.
module operand_bypass_stage_history
  import operand_bypass_stage_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hist_adv,
  input  logic                           wb_valid,
  input  logic [ADDR_W-1:0]              wb_dest,
  input  logic [WIDTH-1:0]               wb_data,
  input  logic                           wb_pend,
  input  logic                           cpl_valid,
  input  logic [ADDR_W-1:0]              cpl_dest,
  input  logic [WIDTH-1:0]               cpl_data,
  input  logic [NUM_OPS-1:0][ADDR_W-1:0] rd_src,
  output logic [NUM_OPS-1:0]             rd_hit,
  output logic [NUM_OPS-1:0]             rd_pend,
  output logic [NUM_OPS-1:0][WIDTH-1:0]  rd_data,
  output logic                           overflow_err
);

  typedef struct packed {
    logic              valid;
    logic              pend;
    logic [ADDR_W-1:0] dest;
    logic [WIDTH-1:0]  data;
  } hist_entry_t;

  hist_entry_t [DEPTH-1:0] hist_q, hist_d, shifted;
  logic                    overflow_q, overflow_d;
  logic                    fill_done;

  // Slot 0 is youngest. The completion fill looks at post-shift positions so a
  // same-cycle advance and completion land on the entry where it ends up.
  always_comb begin
    shifted = hist_q;
    if (hist_adv) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        shifted[i] = hist_q[i-1];
      end
      shifted[0].valid = wb_valid;
      shifted[0].pend  = wb_valid && wb_pend;
      shifted[0].dest  = wb_dest;
      shifted[0].data  = (wb_valid && !wb_pend) ? wb_data : '0;
    end

    hist_d    = shifted;
    fill_done = 1'b0;
    if (cpl_valid) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (!fill_done && shifted[i].valid && shifted[i].pend &&
            (shifted[i].dest == cpl_dest)) begin
          hist_d[i].pend = 1'b0;
          hist_d[i].data = cpl_data;
          fill_done      = 1'b1;
        end
      end
    end

    overflow_d = overflow_q ||
                 (hist_adv && hist_q[DEPTH-1].valid && hist_q[DEPTH-1].pend);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      overflow_q <= overflow_d;
    end
  end

  // Scan oldest to youngest so the last hit written is the youngest one.
  always_comb begin
    rd_hit  = '0;
    rd_pend = '0;
    rd_data = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (hist_q[i].valid && (hist_q[i].dest == rd_src[k])) begin
          rd_hit[k]  = 1'b1;
          rd_pend[k] = hist_q[i].pend;
          rd_data[k] = hist_q[i].data;
        end
      end
    end
  end

  assign overflow_err = overflow_q;

endmodule

// File: rtl/operand_bypass_stage.sv
// Operand bypass stage: resolves sources against the result history and registers
// them toward execute. Define OPERAND_BYPASS_PERF_EN to build the perf counters.
module operand_bypass_stage
  import operand_bypass_stage_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_OPS = DEF_NUM_OPS,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input logic                    clk,
  input logic                    reset,
  operand_bypass_stage_if.slave  bus
);

  logic [NUM_OPS-1:0]            h_hit;
  logic [NUM_OPS-1:0]            h_pend;
  logic [NUM_OPS-1:0][WIDTH-1:0] h_data;
  logic [NUM_OPS-1:0]            cpl_hit;
  logic [NUM_OPS-1:0]            op_wait;
  op_src_e                       op_src [NUM_OPS];
  logic [NUM_OPS-1:0][WIDTH-1:0] res_op;
  logic                          hazard;
  logic                          in_ready;
  logic                          xfer;

  logic                          out_valid_q, out_valid_d;
  logic [NUM_OPS-1:0][WIDTH-1:0] out_op_q, out_op_d;

  operand_bypass_stage_history #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .NUM_OPS (NUM_OPS),
    .ADDR_W  (ADDR_W)
  ) u_history (
    .clk          (clk),
    .reset        (reset),
    .hist_adv     (bus.hist_adv),
    .wb_valid     (bus.wb_valid),
    .wb_dest      (bus.wb_dest),
    .wb_data      (bus.wb_data),
    .wb_pend      (bus.wb_pend),
    .cpl_valid    (bus.cpl_valid),
    .cpl_dest     (bus.cpl_dest),
    .cpl_data     (bus.cpl_data),
    .rd_src       (bus.in_src),
    .rd_hit       (h_hit),
    .rd_pend      (h_pend),
    .rd_data      (h_data),
    .overflow_err (bus.overflow_err)
  );

  // A pending youngest match is only released by a same-cycle completion of that tag.
  always_comb begin
    cpl_hit = '0;
    op_wait = '0;
    res_op  = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      cpl_hit[k] = bus.cpl_valid && (bus.cpl_dest == bus.in_src[k]);
      if (!h_hit[k])       op_src[k] = SRC_RF;
      else if (!h_pend[k]) op_src[k] = SRC_HIST;
      else if (cpl_hit[k]) op_src[k] = SRC_CPL;
      else                 op_src[k] = SRC_WAIT;

      case (op_src[k])
        SRC_RF:   res_op[k] = bus.in_rf[k];
        SRC_HIST: res_op[k] = h_data[k];
        SRC_CPL:  res_op[k] = bus.cpl_data;
        default:  res_op[k] = '0;
      endcase
      op_wait[k] = (op_src[k] == SRC_WAIT);
    end
  end

  assign hazard   = bus.in_valid && (|op_wait);
  assign in_ready = (!out_valid_q || bus.out_ready) && !hazard;
  assign xfer     = bus.in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_op_d    = res_op;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.hazard    = hazard;
  assign bus.out_valid = out_valid_q;
  assign bus.out_op    = out_op_q;

`ifdef OPERAND_BYPASS_PERF_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Any history hit on a transfer was served by history or by the completion.
  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer && (|h_hit)) fwd_cnt_d = sat_inc(fwd_cnt_q);
    if (hazard)           stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.perf_fwd_cnt   = fwd_cnt_q;
  assign bus.perf_stall_cnt = stall_cnt_q;
`else
  assign bus.perf_fwd_cnt   = '0;
  assign bus.perf_stall_cnt = '0;
`endif

endmodule
